// File: rtl/wave_sample_player.sv
// wave_sample_player
//   Multi-channel sample playback engine. At reset it reads a sample
//   directory (start/length per channel) from the head of the wave region,
//   then on every sample tick walks all channels, fetches one word for each
//   active channel, sums them and emits one saturated signed 16-bit sample.
//
// Ports
//   clock_24   system clock (only clock)
//   reset      synchronous, active-high
//   trigger    rising edge on bit k starts/restarts sample k
//   loop       level; while high, sample k wraps to its start at its end
//   wave_addr  SDRAM word address of the current read
//   wave_rd    one-cycle read strobe
//   wave_data  read data, valid RD_LAT cycles after wave_rd
//   audio_out  signed mixed sample, updated once per tick
//   dir_ready  high once the directory has been loaded
module wave_sample_player #(
    parameter int unsigned NUM_SAMPLES = 12,
    parameter int unsigned RD_LAT      = 4,
    parameter int unsigned SAMPLE_DIV  = 1088
) (
    input  logic                   clock_24,
    input  logic                   reset,
    input  logic [NUM_SAMPLES-1:0] trigger,
    input  logic [NUM_SAMPLES-1:0] loop,
    output logic [19:0]            wave_addr,
    output logic                   wave_rd,
    input  logic [15:0]            wave_data,
    output logic [15:0]            audio_out,
    output logic                   dir_ready
);

    localparam int unsigned DIR_WORDS = 4 * NUM_SAMPLES;
    localparam int unsigned DIR_W     = $clog2(DIR_WORDS);
    localparam int unsigned CH_W      = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;
    localparam int unsigned LAT_W     = $clog2(RD_LAT + 1);
    localparam int unsigned TICK_W    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    localparam logic [DIR_W-1:0]  DIR_LAST  = DIR_W'(DIR_WORDS - 1);
    localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(NUM_SAMPLES - 1);
    localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(RD_LAT);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_DIV - 1);

    typedef enum logic [1:0] {
        DIR_LOAD,
        IDLE,
        MIX,
        OUT
    } state_t;

    state_t state, state_next;

    logic [TICK_W-1:0]      tick_cnt;
    logic                   tick;

    logic [NUM_SAMPLES-1:0] trig_q;
    logic [NUM_SAMPLES-1:0] trig_edge;
    logic [NUM_SAMPLES-1:0] pend;
    logic [NUM_SAMPLES-1:0] active;
    logic [19:0]            pos        [NUM_SAMPLES];
    logic [19:0]            start_addr [NUM_SAMPLES];
    logic [19:0]            length     [NUM_SAMPLES];

    logic                   rd_busy;
    logic [LAT_W-1:0]       wait_cnt;
    logic                   rd_capture;

    logic [DIR_W-1:0]       dir_idx;
    logic [CH_W-1:0]        dir_ent;
    logic [CH_W-1:0]        ch;
    logic [19:0]            pos_inc;

    logic signed [19:0]     acc;
    logic [15:0]            acc_sat;

    always_comb begin
        tick       = (tick_cnt == TICK_LAST);
        trig_edge  = trigger & ~trig_q;
        // wait_cnt is 0 in the strobe cycle, so data is present when it reaches RD_LAT
        rd_capture = rd_busy && (wait_cnt == LAT_LAST);
        dir_ent    = CH_W'(dir_idx >> 2);
        pos_inc    = pos[ch] + 20'd1;
    end

    always_comb begin
        if (acc > 20'sd32767) begin
            acc_sat = 16'h7FFF;
        end else if (acc < -20'sd32768) begin
            acc_sat = 16'h8000;
        end else begin
            acc_sat = acc[15:0];
        end
    end

    always_ff @(posedge clock_24) begin
        if (reset) begin
            state <= DIR_LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            DIR_LOAD: if (rd_capture && (dir_idx == DIR_LAST)) state_next = IDLE;
            IDLE:     if (tick) state_next = MIX;
            MIX:      if ((ch == CH_LAST) && (!active[ch] || rd_capture)) state_next = OUT;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock_24) begin
        if (reset) begin
            tick_cnt  <= '0;
            trig_q    <= '0;
            pend      <= '0;
            active    <= '0;
            for (int unsigned i = 0; i < NUM_SAMPLES; i++) begin
                pos[i]        <= '0;
                start_addr[i] <= '0;
                length[i]     <= '0;
            end
            rd_busy   <= 1'b0;
            wait_cnt  <= '0;
            dir_idx   <= '0;
            ch        <= '0;
            acc       <= '0;
            wave_addr <= '0;
            wave_rd   <= 1'b0;
            audio_out <= '0;
            dir_ready <= 1'b0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            trig_q   <= trigger;
            wave_rd  <= 1'b0;

            if (rd_busy && !rd_capture) begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            if (state != DIR_LOAD) begin
                pend <= pend | trig_edge;
            end

            case (state)
                DIR_LOAD: begin
                    if (!rd_busy) begin
                        wave_rd   <= 1'b1;
                        wave_addr <= 20'(dir_idx);
                        rd_busy   <= 1'b1;
                        wait_cnt  <= '0;
                    end else if (rd_capture) begin
                        case (dir_idx[1:0])
                            2'd0:    start_addr[dir_ent][15:0]  <= wave_data;
                            2'd1:    start_addr[dir_ent][19:16] <= wave_data[3:0];
                            2'd2:    length[dir_ent][15:0]      <= wave_data;
                            default: length[dir_ent][19:16]     <= wave_data[3:0];
                        endcase
                        if (dir_idx == DIR_LAST) begin
                            rd_busy   <= 1'b0;
                            dir_ready <= 1'b1;
                        end else begin
                            // next directory read goes out right behind the capture
                            dir_idx   <= dir_idx + 1'b1;
                            wave_rd   <= 1'b1;
                            wave_addr <= 20'(dir_idx + 1'b1);
                            wait_cnt  <= '0;
                        end
                    end
                end

                IDLE: begin
                    if (tick) begin
                        for (int unsigned i = 0; i < NUM_SAMPLES; i++) begin
                            if (pend[i]) begin
                                active[i] <= (length[i] != '0);
                                pos[i]    <= '0;
                            end
                        end
                        // every pending bit is consumed; only a same-cycle edge survives
                        pend <= trig_edge;
                        ch   <= '0;
                        acc  <= '0;
                    end
                end

                MIX: begin
                    if (!active[ch]) begin
                        ch <= ch + 1'b1;
                    end else if (!rd_busy) begin
                        wave_rd   <= 1'b1;
                        wave_addr <= start_addr[ch] + pos[ch];
                        rd_busy   <= 1'b1;
                        wait_cnt  <= '0;
                    end else if (rd_capture) begin
                        acc     <= acc + {{4{wave_data[15]}}, wave_data};
                        rd_busy <= 1'b0;
                        ch      <= ch + 1'b1;
                        if (pos_inc == length[ch]) begin
                            pos[ch] <= '0;
                            if (!loop[ch]) begin
                                active[ch] <= 1'b0;
                            end
                        end else begin
                            pos[ch] <= pos_inc;
                        end
                    end
                end

                default: begin
                    audio_out <= acc_sat;
                    acc       <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wave_sample_player.sv
// tb_wave_sample_player
//   Bench for wave_sample_player: SDRAM read model with fixed latency, a
//   directory of test sounds, a per-tick vector table feeding a scoreboard,
//   and hand-written sequences for directory load and reset during a read.
module tb_wave_sample_player;

    localparam int unsigned NS  = 12;
    localparam int unsigned LAT = 4;
    localparam int unsigned DIV = 1088;
    localparam int unsigned MID = DIV / 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NS-1:0] trigger = '0;
    logic [NS-1:0] loop = '0;
    logic [19:0]   wave_addr;
    logic          wave_rd;
    logic [15:0]   wave_data = 16'hDEAD;
    logic [15:0]   audio_out;
    logic          dir_ready;

    always #5 clk = ~clk;

    wave_sample_player #(
        .NUM_SAMPLES(NS),
        .RD_LAT     (LAT),
        .SAMPLE_DIV (DIV)
    ) dut (
        .clock_24 (clk),
        .reset    (reset),
        .trigger  (trigger),
        .loop     (loop),
        .wave_addr(wave_addr),
        .wave_rd  (wave_rd),
        .wave_data(wave_data),
        .audio_out(audio_out),
        .dir_ready(dir_ready)
    );

    // ---------------- SDRAM model ----------------
    logic [15:0] mem [logic [19:0]];

    function automatic logic [15:0] mem_rd(input logic [19:0] a);
        if (mem.exists(a)) return mem[a];
        return 16'h0BAD;
    endfunction

    logic [LAT-1:0] pv = '0;
    logic [19:0]    pa [LAT];

    always @(posedge clk) begin
        pv[0] <= wave_rd;
        pa[0] <= wave_addr;
        for (int i = 1; i < LAT; i++) begin
            pv[i] <= pv[i-1];
            pa[i] <= pa[i-1];
        end
        wave_data <= pv[LAT-2] ? mem_rd(pa[LAT-2]) : 16'hDEAD;
    end

    // sample-period phase, restarted by reset like the design's tick counter
    int unsigned ph = 0;
    always @(posedge clk) begin
        if (reset) ph <= 0;
        else       ph <= (ph == DIV - 1) ? 0 : ph + 1;
    end

    // read monitor
    int unsigned rd_count = 0;
    logic [19:0] last_addr = '0;
    always @(negedge clk) begin
        if (wave_rd) begin
            rd_count  = rd_count + 1;
            last_addr = wave_addr;
        end
    end

    // ---------------- checking ----------------
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    task automatic wait_mid();
        int unsigned n = 0;
        @(negedge clk);
        while (ph != MID && n < 2 * DIV) begin
            @(negedge clk);
            n++;
        end
        if (ph != MID) begin
            n_checks++;
            $display("FAIL mid_wait: timed out at phase %0d", ph);
        end
    endtask

    task automatic set_entry(input int k, input logic [19:0] st, input logic [19:0] len);
        mem[20'(4*k)]   = st[15:0];
        mem[20'(4*k+1)] = 16'hABC0 | {12'h000, st[19:16]};
        mem[20'(4*k+2)] = len[15:0];
        mem[20'(4*k+3)] = 16'h5A50 | {12'h000, len[19:16]};
    endtask

    typedef struct {
        logic [NS-1:0] trig;
        logic [NS-1:0] lp;
        logic [15:0]   audio;
        int unsigned   reads;
        logic [19:0]   addr;
    } vec_t;

    typedef struct {
        logic [15:0] audio;
        int unsigned reads;
        logic [19:0] addr;
    } exp_t;

    vec_t vt[$];
    exp_t sb[$];

    task automatic add(input logic [NS-1:0] trig, input logic [NS-1:0] lp,
                       input logic [15:0] audio, input int unsigned reads, input logic [19:0] addr);
        vec_t v;
        v.trig = trig; v.lp = lp; v.audio = audio; v.reads = reads; v.addr = addr;
        vt.push_back(v);
    endtask

    initial begin
        int          last_c;
        int          dir_c;
        int unsigned nrd;
        int unsigned base;
        int unsigned rd_before;
        int unsigned found;
        vec_t        v;
        exp_t        e;

        // directory and sample data
        set_entry(0,  20'h00100, 20'd3);
        set_entry(1,  20'h00200, 20'd2);
        set_entry(2,  20'h00300, 20'd2);
        set_entry(3,  20'h12345, 20'd3);
        set_entry(4,  20'h00400, 20'd2);
        set_entry(5,  20'h00500, 20'd2);
        set_entry(6,  20'h00600, 20'd5);
        set_entry(7,  20'h00700, 20'd0);
        set_entry(8,  20'hFFFFE, 20'd3);
        set_entry(9,  20'h00800, 20'd0);
        set_entry(10, 20'h00800, 20'd0);
        set_entry(11, 20'h00800, 20'd0);
        mem[20'h00100] = 16'h0100; mem[20'h00101] = 16'h0200; mem[20'h00102] = 16'h0300;
        mem[20'h00200] = 16'h7000; mem[20'h00201] = 16'h7000;
        mem[20'h00300] = 16'h7000; mem[20'h00301] = 16'h7000;
        mem[20'h00400] = 16'h9000; mem[20'h00401] = 16'h9000;
        mem[20'h00500] = 16'h9000; mem[20'h00501] = 16'h9000;
        mem[20'h12345] = 16'h0011; mem[20'h12346] = 16'h0022; mem[20'h12347] = 16'h0033;
        for (int i = 0; i < 5; i++) mem[20'(20'h00600 + i)] = 16'(i + 1);
        mem[20'h00700] = 16'h4444;
        mem[20'hFFFFE] = 16'h0005; mem[20'hFFFFF] = 16'h0006;

        // one row per sample period: inputs applied, then the next pass is checked
        add(12'h000, 12'h000, 16'h0000, 0, 20'h0);          // idle
        add(12'h001, 12'h000, 16'h0100, 1, 20'h00100);      // one-shot
        add(12'h000, 12'h000, 16'h0200, 1, 20'h00101);
        add(12'h000, 12'h000, 16'h0300, 1, 20'h00102);
        add(12'h000, 12'h000, 16'h0000, 0, 20'h0);
        add(12'h001, 12'h001, 16'h0100, 1, 20'h00100);      // looped
        add(12'h000, 12'h001, 16'h0200, 1, 20'h00101);
        add(12'h000, 12'h001, 16'h0300, 1, 20'h00102);
        add(12'h000, 12'h001, 16'h0100, 1, 20'h00100);
        add(12'h000, 12'h001, 16'h0200, 1, 20'h00101);
        add(12'h000, 12'h000, 16'h0300, 1, 20'h00102);      // loop dropped
        add(12'h000, 12'h000, 16'h0000, 0, 20'h0);
        add(12'h006, 12'h000, 16'h7FFF, 2, 20'h0);          // positive clamp
        add(12'h000, 12'h000, 16'h7FFF, 2, 20'h0);
        add(12'h000, 12'h000, 16'h0000, 0, 20'h0);
        add(12'h030, 12'h000, 16'h8000, 2, 20'h0);          // negative clamp
        add(12'h000, 12'h000, 16'h8000, 2, 20'h0);
        add(12'h000, 12'h000, 16'h0000, 0, 20'h0);
        add(12'h011, 12'h000, 16'h9100, 2, 20'h0);          // signed mix
        add(12'h000, 12'h000, 16'h9200, 2, 20'h0);
        add(12'h000, 12'h000, 16'h0300, 1, 20'h00102);
        add(12'h000, 12'h000, 16'h0000, 0, 20'h0);
        add(12'h008, 12'h000, 16'h0011, 1, 20'h12345);      // 20-bit start
        add(12'h000, 12'h000, 16'h0022, 1, 20'h12346);
        add(12'h000, 12'h000, 16'h0033, 1, 20'h12347);
        add(12'h000, 12'h000, 16'h0000, 0, 20'h0);
        add(12'h100, 12'h000, 16'h0005, 1, 20'hFFFFE);      // address wrap
        add(12'h000, 12'h000, 16'h0006, 1, 20'hFFFFF);
        add(12'h000, 12'h000, 16'h0100, 1, 20'h00000);
        add(12'h000, 12'h000, 16'h0000, 0, 20'h0);
        add(12'h080, 12'h000, 16'h0000, 0, 20'h0);          // zero length
        add(12'h040, 12'h000, 16'h0001, 1, 20'h00600);      // retrigger
        add(12'h000, 12'h000, 16'h0002, 1, 20'h00601);
        add(12'h040, 12'h000, 16'h0001, 1, 20'h00600);
        add(12'h000, 12'h000, 16'h0002, 1, 20'h00601);
        add(12'h000, 12'h000, 16'h0003, 1, 20'h00602);
        add(12'h000, 12'h000, 16'h0004, 1, 20'h00603);
        add(12'h000, 12'h000, 16'h0005, 1, 20'h00604);
        add(12'h000, 12'h000, 16'h0000, 0, 20'h0);

        // reset state
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_audio", 32'(audio_out), 32'h0);
        check("rst_wave_rd", 32'(wave_rd), 32'h0);
        check("rst_wave_addr", 32'(wave_addr), 32'h0);
        check("rst_dir_ready", 32'(dir_ready), 32'h0);
        reset = 1'b0;

        // directory load
        last_c = 0;
        dir_c  = -1;
        nrd    = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (wave_rd) begin
                check($sformatf("dir_addr%0d", nrd), 32'(wave_addr), 32'(nrd));
                if (nrd > 0) check($sformatf("dir_gap%0d", nrd), 32'(c - last_c), 32'(LAT + 1));
                last_c = c;
                nrd++;
            end
            if (dir_ready) begin
                dir_c = c;
                break;
            end
        end
        check("dir_reads", 32'(nrd), 32'(4 * NS));
        check("dir_ready_delay", 32'(dir_c - last_c), 32'(LAT + 1));

        // table with scoreboard
        wait_mid();
        base = rd_count;
        for (int i = 0; i < vt.size(); i++) begin
            v = vt[i];
            trigger = v.trig;
            loop    = v.lp;
            e.audio = v.audio; e.reads = v.reads; e.addr = v.addr;
            sb.push_back(e);
            wait_mid();
            e = sb.pop_front();
            check($sformatf("row%0d_audio", i), 32'(audio_out), 32'(e.audio));
            check($sformatf("row%0d_reads", i), rd_count - base, 32'(e.reads));
            if (e.reads == 1) check($sformatf("row%0d_addr", i), 32'(last_addr), 32'(e.addr));
            base = rd_count;
        end

        // reset between a read strobe and its capture
        trigger = 12'h001;
        loop    = 12'h001;
        wait_mid();
        trigger = 12'h000;
        wait_mid();
        check("abort_pre_audio", 32'(audio_out), 32'h0200);
        found = 0;
        for (int i = 0; i < 2 * DIV && found == 0; i++) begin
            @(negedge clk);
            if (wave_rd) found = 1;
        end
        check("abort_rd_seen", found, 1);
        @(negedge clk);
        reset = 1'b1;
        rd_before = rd_count;
        @(negedge clk);
        check("abort_audio", 32'(audio_out), 32'h0);
        check("abort_wave_rd", 32'(wave_rd), 32'h0);
        check("abort_wave_addr", 32'(wave_addr), 32'h0);
        check("abort_dir_ready", 32'(dir_ready), 32'h0);
        repeat (2) @(negedge clk);
        check("abort_no_rd", rd_count - rd_before, 0);
        loop  = 12'h000;
        reset = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            @(negedge clk);
            if (wave_rd) found = 1;
        end
        check("reload_first_rd", found, 1);
        check("reload_first_addr", 32'(wave_addr), 32'h0);
        for (int i = 0; i < 600 && !dir_ready; i++) @(negedge clk);
        check("reload_ready", 32'(dir_ready), 32'h1);
        wait_mid();
        trigger = 12'h001;
        wait_mid();
        check("reload_play", 32'(audio_out), 32'h0100);
        trigger = 12'h000;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
